// File: rtl/branch_tracker_pkg.sv
// rtl/branch_tracker_pkg.sv - shared types and constants for the branch resolve tracker
package branch_tracker_pkg;

  // Widest PC the entry record can carry; the top zero-extends ADDR_W into it.
  localparam int BT_MAX_ADDR_W = 64;
  localparam int INSTR_BYTES   = 4;

  typedef logic [0:0] bt_state_t;
  localparam bt_state_t RUN     = 1'b0;
  localparam bt_state_t RECOVER = 1'b1;

  typedef struct packed {
    logic [BT_MAX_ADDR_W-1:0] pc;
    logic                     taken;
    logic [BT_MAX_ADDR_W-1:0] target;
  } bt_entry_t;

endpackage

// File: rtl/bt_fifo.sv
// rtl/bt_fifo.sv - in-order prediction entry FIFO with synchronous clear
module bt_fifo
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  bt_entry_t                wr_data_i,
  input  logic                     rd_en_i,
  output bt_entry_t                rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  bt_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q;
  logic              wr_ok, rd_ok;

  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;

  // Pointer and count bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (!nRST || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(wr_ok) - (PW+1)'(rd_ok);
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/branch_resolve_tracker.sv
// rtl/branch_resolve_tracker.sv - tracks in-flight branch predictions, detects mispredicts (optional stats: BR_TRACKER_STATS_EN)
module branch_resolve_tracker
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   pred_valid,
  input  logic [ADDR_W-1:0]      pred_pc,
  input  logic [ADDR_W-1:0]      pred_target,
  input  logic                   pred_taken,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [ADDR_W-1:0]      res_target,
  output logic                   res_ready,
  input  logic                   flush,
  output logic                   mispredict,
  output logic [ADDR_W-1:0]      redirect_pc,
  output logic                   update_predictor,
  output logic [ADDR_W-1:0]      update_pc,
  output logic [ADDR_W-1:0]      update_target,
  output logic                   update_taken,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef BR_TRACKER_STATS_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
`endif
);

  bt_state_t                state_q, state_d;
  bt_entry_t                wr_entry, head;
  logic                     full, empty;
  logic                     deq, enq, mis_det, clr;
  logic [BT_MAX_ADDR_W-1:0] res_target_x;
  logic [ADDR_W-1:0]        redirect_d;

  logic                     mispredict_q, update_q, update_taken_q;
  logic [ADDR_W-1:0]        redirect_pc_q, update_pc_q, update_target_q;

  assign res_target_x = BT_MAX_ADDR_W'(res_target);
  assign wr_entry     = '{pc: BT_MAX_ADDR_W'(pred_pc), taken: pred_taken,
                          target: BT_MAX_ADDR_W'(pred_target)};

  assign pred_ready = (state_q == RUN) && !full;
  assign res_ready  = (state_q == RUN) && !empty;
  assign deq        = res_valid && res_ready;

  // Target only matters when both predicted and actual direction are taken.
  assign mis_det    = deq && ((res_taken != head.taken) ||
                              (res_taken && head.taken && (res_target_x != head.target)));
  assign clr        = flush || mis_det;
  assign enq        = pred_valid && pred_ready && !clr;
  assign redirect_d = res_taken ? res_target
                                : ADDR_W'(head.pc + BT_MAX_ADDR_W'(INSTR_BYTES));

  bt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr_i     (clr),
    .wr_en_i   (enq),
    .wr_data_i (wr_entry),
    .rd_en_i   (deq),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (occupancy)
  );

  // Recovery lasts exactly one cycle, entered on any squash.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN) begin
      if (clr) state_d = RECOVER;
    end else begin
      state_d = RUN;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Registered pulses and their payloads; payloads hold between pulses.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mispredict_q    <= 1'b0;
      update_q        <= 1'b0;
      redirect_pc_q   <= '0;
      update_pc_q     <= '0;
      update_target_q <= '0;
      update_taken_q  <= 1'b0;
    end else begin
      mispredict_q <= mis_det;
      update_q     <= deq;
      if (deq) begin
        update_pc_q     <= ADDR_W'(head.pc);
        update_target_q <= res_target;
        update_taken_q  <= res_taken;
      end
      if (mis_det) redirect_pc_q <= redirect_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign update_predictor = update_q;
  assign update_pc        = update_pc_q;
  assign update_target    = update_target_q;
  assign update_taken     = update_taken_q;

`ifdef BR_TRACKER_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (deq && (stat_br_q != '1))      stat_br_q  <= stat_br_q + 32'd1;
      if (mis_det && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// tb/tb_branch_resolve_tracker.sv - self-checking bench for branch_resolve_tracker
module tb_branch_resolve_tracker;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          pred_valid, pred_taken, res_valid, res_taken, flush;
  logic [AW-1:0] pred_pc, pred_target, res_target;
  logic          pred_ready, res_ready, mispredict, update_predictor, update_taken;
  logic [AW-1:0] redirect_pc, update_pc, update_target;
  logic [2:0]    occupancy;
`ifdef BR_TRACKER_STATS_EN
  logic [31:0]   stat_branches, stat_mispredicts;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  always #5 CLK = ~CLK;

  branch_resolve_tracker #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target),
    .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_ready(res_ready), .flush(flush),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .update_predictor(update_predictor), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .occupancy(occupancy)
`ifdef BR_TRACKER_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of outstanding predictions ----------------
  typedef struct {
    logic [AW-1:0] pc;
    logic          taken;
    logic [AW-1:0] tgt;
  } ent_t;

  ent_t          mq[$];
  ent_t          m_new, m_head;
  bit            m_rec;
  bit            e_mis, e_upd, e_utaken;
  logic [AW-1:0] e_redir, e_upc, e_utgt;
  int unsigned   e_sb, e_sm;
  bit            m_can_pred, m_can_res, m_deq, m_wrong;

  always @(posedge CLK) begin
    if (!nRST) begin
      mq.delete();
      m_rec = 0; e_mis = 0; e_upd = 0; e_sb = 0; e_sm = 0;
    end else begin
      m_can_pred = !m_rec && (mq.size() < DEPTH);
      m_can_res  = !m_rec && (mq.size() != 0);
      m_deq      = res_valid && m_can_res;
      m_wrong    = 0;
      e_upd      = m_deq;
      if (m_deq) begin
        m_head   = mq[0];
        m_wrong  = (res_taken != m_head.taken) || (res_taken && res_target != m_head.tgt);
        e_upc    = m_head.pc;
        e_utgt   = res_target;
        e_utaken = res_taken;
        e_sb++;
        if (m_wrong) begin
          e_redir = res_taken ? res_target : m_head.pc + 32'd4;
          e_sm++;
        end
      end
      e_mis = m_wrong;
      if (flush || m_wrong) begin
        mq.delete();
        m_rec = !m_rec;
      end else begin
        m_rec = 0;
        if (m_deq) void'(mq.pop_front());
        if (pred_valid && m_can_pred) begin
          m_new.pc = pred_pc; m_new.taken = pred_taken; m_new.tgt = pred_target;
          mq.push_back(m_new);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("m_pred_ready", pred_ready, (!m_rec && mq.size() < DEPTH));
      chk("m_res_ready", res_ready, (!m_rec && mq.size() != 0));
      chk("m_occupancy", occupancy, mq.size());
      chk("m_mispredict", mispredict, e_mis);
      chk("m_update", update_predictor, e_upd);
      if (e_upd) begin
        chk("m_update_pc", update_pc, e_upc);
        chk("m_update_target", update_target, e_utgt);
        chk("m_update_taken", update_taken, e_utaken);
      end
      if (e_mis) chk("m_redirect_pc", redirect_pc, e_redir);
`ifdef BR_TRACKER_STATS_EN
      chk("m_stat_branches", stat_branches, e_sb);
      chk("m_stat_mispredicts", stat_mispredicts, e_sm);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    pred_valid = 0; pred_pc = '0; pred_target = '0; pred_taken = 0;
    res_valid = 0; res_taken = 0; res_target = '0; flush = 0;
  endtask

  task automatic step(input bit pv, input logic [AW-1:0] ppc, input bit pt,
                      input logic [AW-1:0] ptg, input bit rv, input bit rt,
                      input logic [AW-1:0] rtg, input bit fl);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg; flush = fl;
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic enq(input logic [AW-1:0] pc, input bit t, input logic [AW-1:0] tg);
    step(1, pc, t, tg, 0, 0, '0, 0);
  endtask

  task automatic res(input bit t, input logic [AW-1:0] tg);
    step(0, '0, 0, '0, 1, t, tg, 0);
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    logic [AW-1:0] pc_i, tg_i, pc_j, tg_j;
    int j;
    nRST = 0;
    idle_inputs();
    @(posedge CLK); #1;
    chk_on = 1;
    @(posedge CLK); #1;

    // Reset state
    chk("rst_pred_ready", pred_ready, 1);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_update", update_predictor, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_update_pc", update_pc, 0);
    chk("rst_update_target", update_target, 0);
    chk("rst_update_taken", update_taken, 0);
    nRST = 1;

    // Correct taken prediction
    enq(32'h100, 1, 32'h200);
    chk("c_occ1", occupancy, 1);
    chk("c_res_ready", res_ready, 1);
    res(1, 32'h200);
    chk("c_update", update_predictor, 1);
    chk("c_update_pc", update_pc, 32'h100);
    chk("c_update_target", update_target, 32'h200);
    chk("c_mispredict", mispredict, 0);
    idle();
    chk("c_update_drop", update_predictor, 0);

    // Not-taken predicted, taken actual
    enq(32'h100, 0, 32'h180);
    res(1, 32'h400);
    chk("d_mispredict", mispredict, 1);
    chk("d_redirect", redirect_pc, 32'h400);
    chk("d_recover_pred_ready", pred_ready, 0);
    chk("d_recover_res_ready", res_ready, 0);
    idle();
    chk("d_mis_drop", mispredict, 0);
    chk("d_run_pred_ready", pred_ready, 1);

    // Taken predicted, not-taken actual, younger entries and same-cycle enqueue squashed
    enq(32'h300, 1, 32'h500);
    enq(32'h310, 0, 32'h0);
    enq(32'h320, 0, 32'h0);
    chk("s_occ3", occupancy, 3);
    step(1, 32'h330, 0, '0, 1, 0, '0, 0);
    chk("s_mispredict", mispredict, 1);
    chk("s_redirect", redirect_pc, 32'h304);
    chk("s_update_pc", update_pc, 32'h300);
    chk("s_occ0", occupancy, 0);
    idle();
    chk("s_occ_after", occupancy, 0);

    // Full FIFO
    for (int i = 0; i < DEPTH; i++) begin
      pc_i = 32'h1000 + 32'(i) * 32'h10;
      enq(pc_i, 0, '0);
    end
    chk("f_pred_ready", pred_ready, 0);
    chk("f_occ4", occupancy, 4);
    enq(32'h2000, 0, '0);
    chk("f_occ_rejected", occupancy, 4);
    step(1, 32'h2000, 0, '0, 1, 0, '0, 0);
    chk("f_occ3", occupancy, 3);
    chk("f_update_pc", update_pc, 32'h1000);
    chk("f_mispredict", mispredict, 0);
    res(0, '0); res(0, '0); res(0, '0);
    chk("f_last_pc", update_pc, 32'h1030);
    chk("f_drained", occupancy, 0);

    // Flush with simultaneous correct resolution
    enq(32'h100, 1, 32'h200);
    enq(32'h140, 0, 32'h0);
    step(1, 32'h180, 0, '0, 1, 1, 32'h200, 1);
    chk("fl_update", update_predictor, 1);
    chk("fl_update_pc", update_pc, 32'h100);
    chk("fl_mispredict", mispredict, 0);
    chk("fl_occ0", occupancy, 0);
    chk("fl_pred_ready", pred_ready, 0);
    idle();
    chk("fl_run", pred_ready, 1);

    // Wrong target on taken/taken
    enq(32'h700, 1, 32'h800);
    res(1, 32'h900);
    chk("t_mispredict", mispredict, 1);
    chk("t_redirect", redirect_pc, 32'h900);
    idle();

    // pc+4 wraps modulo 2^ADDR_W
    enq(32'hFFFF_FFFC, 1, 32'h10);
    res(0, '0);
    chk("w_mispredict", mispredict, 1);
    chk("w_redirect", redirect_pc, 32'h0);
    idle();

    // Resolve while empty is ignored
    res(1, 32'h40);
    chk("e_update", update_predictor, 0);
    chk("e_mispredict", mispredict, 0);

    // Flush arriving during RECOVER
    enq(32'h50, 0, '0);
    res(1, 32'h60);
    step(1, 32'h70, 0, '0, 0, 0, '0, 1);
    chk("r_occ", occupancy, 0);
    chk("r_pred_ready", pred_ready, 1);

    // Steady stream, pointers wrap several times
    for (int i = 0; i < 24; i++) begin
      pc_i = 32'h4000 + 32'(i) * 32'd4;
      tg_i = 32'h8000 + 32'(i) * 32'd8;
      j = i - 2;
      pc_j = 32'h8000 + 32'(j) * 32'd8;
      tg_j = 32'(j & 1);
      step(1, pc_i, i[0], tg_i, (i >= 2), tg_j[0], pc_j, 0);
    end
    chk("st_occ2", occupancy, 2);
    chk("st_update_pc", update_pc, 32'h4000 + 32'd21 * 32'd4);
    res(0, '0);
    res(1, 32'h8000 + 32'd23 * 32'd8);
    chk("st_drained", occupancy, 0);

    // Reset mid-operation with a pending mispredict
    enq(32'h900, 1, 32'hA00);
    enq(32'h910, 1, 32'hA00);
    enq(32'h920, 1, 32'hA00);
    nRST = 0;
    res(0, '0);
    chk("x_mispredict", mispredict, 0);
    chk("x_update", update_predictor, 0);
    chk("x_redirect", redirect_pc, 0);
    chk("x_update_pc", update_pc, 0);
    chk("x_update_target", update_target, 0);
    chk("x_occ", occupancy, 0);
`ifdef BR_TRACKER_STATS_EN
    chk("x_stat_branches", stat_branches, 0);
    chk("x_stat_mispredicts", stat_mispredicts, 0);
`endif
    nRST = 1;
    idle();
    chk("x_pred_ready", pred_ready, 1);
    chk("x_res_ready", res_ready, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
